// File: rtl/ibex_pkg.sv
// Shared types for the writeback stage: instruction classes and held-entry layout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ibex_pkg;

  // Class of an instruction leaving EX; decides how writeback completes it.
  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  // Everything the buffer remembers about the instruction it holds.
  typedef struct packed {
    wb_instr_type_e instr_type;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic           we;
  } wb_entry_t;

  // Loads and stores wait for the LSU; everything else completes on its own.
  function automatic logic waits_for_lsu(input wb_instr_type_e t);
    return (t == WB_INSTR_LOAD) || (t == WB_INSTR_STORE);
  endfunction

endpackage

// File: rtl/ibex_counter.sv
// Free-running event counter: adds one per cycle with inc_i high, wraps at 2^CounterWidth.
// Latency: count visible one cycle after the increment request.
// Backpressure: none; every request is counted.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset, clears the count
//   inc_i      increment request
//   counter_o  current count
module ibex_counter #(
  parameter int unsigned CounterWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    inc_i,
  output logic [CounterWidth-1:0] counter_o
);

  localparam logic [CounterWidth-1:0] One = CounterWidth'(1);

  logic [CounterWidth-1:0] counter_q;

  // Plain modular add: no saturation, the count simply wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_q <= '0;
    end else if (inc_i) begin
      counter_q <= counter_q + One;
    end
  end

  assign counter_o = counter_q;

endmodule

// File: rtl/ibex_wb_buffer.sv
// Single-entry writeback buffer between EX and the register file, with retire counting.
// Latency: non-memory instructions complete 1 cycle after capture; loads/stores on LSU response.
// Backpressure: ready_wb_o low while the held entry is incomplete; same-cycle replace on completion.
//
// Ports:
//   clk_i, rst_i               clock and synchronous active-high reset
//   en_wb_i / ready_wb_o       EX -> WB handshake (transfer when both high)
//   instr_type_wb_i, rf_*_id_i offered instruction: class, dest reg, EX result, write enable
//   lsu_resp_valid_i/_err_i    LSU response strobe and bus-error flag, rf_wdata_lsu_i load data
//   rf_*_wb_o                  register-file write port
//   rf_wdata_fwd_wb_o          held EX result for operand forwarding
//   outstanding_load_wb_o      held instruction is a load still waiting
//   instr_done_wb_o            held instruction completes this cycle
//   lsu_err_wb_o               completing load/store reported a bus error
//   retire_cnt_o               completed-instruction count
module ibex_wb_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned RetireCntWidth = 32,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      en_wb_i,
  input  logic [1:0]                instr_type_wb_i,
  input  logic [4:0]                rf_waddr_id_i,
  input  logic [31:0]               rf_wdata_id_i,
  input  logic                      rf_we_id_i,

  input  logic                      lsu_resp_valid_i,
  input  logic                      lsu_resp_err_i,
  input  logic [31:0]               rf_wdata_lsu_i,

  output logic                      ready_wb_o,
  output logic [4:0]                rf_waddr_wb_o,
  output logic [31:0]               rf_wdata_wb_o,
  output logic                      rf_we_wb_o,
  output logic [31:0]               rf_wdata_fwd_wb_o,
  output logic                      outstanding_load_wb_o,
  output logic                      instr_done_wb_o,
  output logic                      lsu_err_wb_o,
  output logic [RetireCntWidth-1:0] retire_cnt_o
);

  wb_entry_t      entry_q;
  wb_entry_t      entry_d;
  logic           wb_valid_q;
  wb_instr_type_e held_type;
  logic           transfer;
  logic           done;
  logic           write_ok;

  assign held_type = entry_q.instr_type;

  assign entry_d.instr_type = wb_instr_type_e'(instr_type_wb_i);
  assign entry_d.waddr      = rf_waddr_id_i;
  assign entry_d.wdata      = rf_wdata_id_i;
  assign entry_d.we         = rf_we_id_i;

  // Completion. A response arriving while nothing memory-bound is held is
  // simply ignored. Reset suppresses completion so that an instruction
  // dropped by reset never writes, retires or flags an error.
  always_comb begin
    done = 1'b0;
    if (wb_valid_q && !rst_i) begin
      if (waits_for_lsu(held_type)) begin
        done = lsu_resp_valid_i;
      end else begin
        done = 1'b1;
      end
    end
  end

  // Ready depends only on held state and LSU inputs, never on en_wb_i,
  // so there is no combinational loop through the handshake.
  assign ready_wb_o = ~wb_valid_q | done;
  assign transfer   = en_wb_i & ready_wb_o;

  // Whether the completing instruction is allowed to write, by class.
  always_comb begin
    write_ok = 1'b0;
    unique case (held_type)
      WB_INSTR_OTHER: write_ok = entry_q.we;
      WB_INSTR_LOAD:  write_ok = entry_q.we & ~lsu_resp_err_i;
      default:        write_ok = 1'b0;
    endcase
  end

  // x0 is hardwired to zero, so writes to it are squashed here.
  assign rf_we_wb_o = done & write_ok & (entry_q.waddr != 5'd0);

  // Data outputs read zero when empty so stale (possibly unreset) entry
  // contents never appear on the port.
  assign rf_waddr_wb_o     = wb_valid_q ? entry_q.waddr : 5'd0;
  assign rf_wdata_fwd_wb_o = wb_valid_q ? entry_q.wdata : 32'd0;
  always_comb begin
    rf_wdata_wb_o = 32'd0;
    if (wb_valid_q) begin
      rf_wdata_wb_o = (held_type == WB_INSTR_LOAD) ? rf_wdata_lsu_i : entry_q.wdata;
    end
  end

  assign outstanding_load_wb_o = wb_valid_q & (held_type == WB_INSTR_LOAD);
  assign lsu_err_wb_o          = done & waits_for_lsu(held_type) & lsu_resp_err_i;
  assign instr_done_wb_o       = done;

  // Occupancy: a new transfer wins over completion, which lets a finishing
  // entry be replaced in the same cycle without a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
    end else if (transfer) begin
      wb_valid_q <= 1'b1;
    end else if (done) begin
      wb_valid_q <= 1'b0;
    end
  end

  // Payload registers. Without ResetAll they only load on a transfer; their
  // post-reset contents are masked by wb_valid_q.
  always_ff @(posedge clk_i) begin
    if (ResetAll && rst_i) begin
      entry_q.instr_type <= WB_INSTR_OTHER;
      entry_q.waddr      <= 5'd0;
      entry_q.wdata      <= 32'd0;
      entry_q.we         <= 1'b0;
    end else if (transfer) begin
      entry_q <= entry_d;
    end
  end

  ibex_counter #(
    .CounterWidth (RetireCntWidth)
  ) u_retire_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (done),
    .counter_o (retire_cnt_o)
  );

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// Self-checking bench for ibex_wb_buffer: directed scenarios plus randomized traffic
// checked each cycle against a single-entry behavioural model.
// Two DUTs share stimulus: 32-bit counter / ResetAll=0 and 4-bit counter / ResetAll=1.
module tb_ibex_wb_buffer;
  import ibex_pkg::*;

  localparam logic [1:0] T_LD = 2'b00;
  localparam logic [1:0] T_ST = 2'b01;
  localparam logic [1:0] T_OT = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  typ = T_OT;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        lsu_vld = 1'b0;
  logic        lsu_err = 1'b0;
  logic [31:0] lsu_dat = '0;

  logic        ready_a, we_a, out_a, done_a, err_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a, fwd_a, cnt_a;
  logic        ready_b, we_b, out_b, done_b, err_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b, fwd_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  ibex_wb_buffer #(.RetireCntWidth(32), .ResetAll(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_wb_i(en), .instr_type_wb_i(typ),
    .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we),
    .lsu_resp_valid_i(lsu_vld), .lsu_resp_err_i(lsu_err), .rf_wdata_lsu_i(lsu_dat),
    .ready_wb_o(ready_a), .rf_waddr_wb_o(waddr_a), .rf_wdata_wb_o(wdata_a),
    .rf_we_wb_o(we_a), .rf_wdata_fwd_wb_o(fwd_a), .outstanding_load_wb_o(out_a),
    .instr_done_wb_o(done_a), .lsu_err_wb_o(err_a), .retire_cnt_o(cnt_a));

  ibex_wb_buffer #(.RetireCntWidth(4), .ResetAll(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_wb_i(en), .instr_type_wb_i(typ),
    .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we),
    .lsu_resp_valid_i(lsu_vld), .lsu_resp_err_i(lsu_err), .rf_wdata_lsu_i(lsu_dat),
    .ready_wb_o(ready_b), .rf_waddr_wb_o(waddr_b), .rf_wdata_wb_o(wdata_b),
    .rf_we_wb_o(we_b), .rf_wdata_fwd_wb_o(fwd_b), .outstanding_load_wb_o(out_b),
    .instr_done_wb_o(done_b), .lsu_err_wb_o(err_b), .retire_cnt_o(cnt_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one slot, described by its rules ----
  bit              m_known = 0;
  bit              m_valid = 0;
  logic [1:0]      m_type = T_OT;
  logic [4:0]      m_waddr = '0;
  logic [31:0]     m_wdata = '0;
  bit              m_we = 0;
  longint unsigned m_cnt = 0;
  bit              took = 0;
  bit              e_done, e_ready, e_err, e_we, e_out;
  logic [31:0]     e_wdata;

  always @(negedge clk) begin
    // A held instruction finishes now if it needs nothing, or if it is a
    // load/store and the LSU answers. Nothing finishes under reset.
    e_done  = !rst && m_valid && (m_type == T_OT || lsu_vld);
    e_ready = !m_valid || e_done;
    e_err   = e_done && (m_type != T_OT) && lsu_err;
    e_we    = e_done && m_we && (m_waddr != 5'd0) &&
              ((m_type == T_OT) || (m_type == T_LD && !lsu_err));
    e_wdata = (m_type == T_LD) ? lsu_dat : m_wdata;
    e_out   = m_valid && (m_type == T_LD);
    if (m_known) begin
      chk("done_a", done_a, e_done);
      chk("we_a",   we_a,   e_we);
      chk("err_a",  err_a,  e_err);
      chk("done_b", done_b, e_done);
      chk("we_b",   we_b,   e_we);
      if (!rst) begin
        chk("ready_a", ready_a, e_ready);
        chk("out_a",   out_a,   e_out);
        chk("cnt_a",   cnt_a,   m_cnt[31:0]);
        chk("cnt_b",   cnt_b,   m_cnt[3:0]);
        if (m_valid) chk("fwd_a", fwd_a, m_wdata);
        if (e_we) begin
          chk("waddr_a", waddr_a, m_waddr);
          chk("wdata_a", wdata_a, e_wdata);
        end
      end
    end
    took = en && e_ready && !rst;
    if (rst) begin
      m_valid = 0;
      m_cnt   = 0;
      m_known = 1;
    end else begin
      if (e_done) m_cnt++;
      if (took) begin
        m_valid = 1; m_type = typ; m_waddr = waddr; m_wdata = wdata; m_we = we;
      end else if (e_done) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic offer(input logic [1:0] t, input logic [4:0] a,
                       input logic [31:0] d, input logic w);
    en = 1'b1; typ = t; waddr = a; wdata = d; we = w;
  endtask

  task automatic idle();
    en = 1'b0; lsu_vld = 1'b0; lsu_err = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; mid(); tick(); rst = 1'b0;
  endtask

  int writes;

  initial begin
    // reset and idle state
    rst = 1'b1; mid(); tick(); mid(); tick(); rst = 1'b0;
    mid();
    chk("rst_ready", ready_a, 1); chk("rst_we", we_a, 0); chk("rst_done", done_a, 0);
    chk("rst_cnt", cnt_a, 0); chk("rst_out", out_a, 0); chk("rst_err", err_a, 0);
    tick();

    // single OTHER instruction
    offer(T_OT, 5'd5, 32'hDEADBEEF, 1'b1); mid(); tick();
    idle(); mid();
    chk("oth_we", we_a, 1); chk("oth_waddr", waddr_a, 5); chk("oth_wdata", wdata_a, 32'hDEADBEEF);
    chk("oth_done", done_a, 1);
    tick(); mid(); chk("oth_cnt", cnt_a, 1); tick();

    // load answered four cycles after capture
    offer(T_LD, 5'd3, 32'h0, 1'b1); mid(); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      mid(); chk("ld_wait_out", out_a, 1); chk("ld_wait_ready", ready_a, 0); tick();
    end
    lsu_vld = 1'b1; lsu_dat = 32'h12345678; mid();
    chk("ld_we", we_a, 1); chk("ld_waddr", waddr_a, 3); chk("ld_wdata", wdata_a, 32'h12345678);
    chk("ld_ready", ready_a, 1);
    tick(); idle(); mid(); chk("ld_after_out", out_a, 0); tick();

    // ten back-to-back OTHER instructions
    do_reset();
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      offer(T_OT, 5'(i + 1), $urandom, 1'b1); mid();
      chk("b2b_ready", ready_a, 1);
      if (i > 0) writes += int'(we_a);
      tick();
    end
    idle(); mid(); writes += int'(we_a); tick();
    mid(); chk("b2b_writes", writes, 10); chk("b2b_cnt", cnt_a, 10); tick();

    // load with bus error, then clean store
    offer(T_LD, 5'd7, 32'h0, 1'b1); mid(); tick();
    idle(); lsu_vld = 1'b1; lsu_err = 1'b1; lsu_dat = $urandom; mid();
    chk("lderr_we", we_a, 0); chk("lderr_err", err_a, 1); chk("lderr_done", done_a, 1);
    tick(); idle(); mid(); chk("lderr_pulse", err_a, 0); tick();
    offer(T_ST, 5'd9, $urandom, 1'b1); mid(); tick();
    idle(); lsu_vld = 1'b1; mid();
    chk("st_we", we_a, 0); chk("st_done", done_a, 1); chk("st_err", err_a, 0);
    tick(); idle(); mid(); tick();

    // write to x0 and a stray LSU response while empty
    offer(T_OT, 5'd0, $urandom, 1'b1); mid(); tick();
    idle(); mid(); chk("x0_we", we_a, 0); chk("x0_done", done_a, 1); tick();
    lsu_vld = 1'b1; lsu_dat = $urandom; mid();
    chk("stray_we", we_a, 0); chk("stray_done", done_a, 0); chk("stray_ready", ready_a, 1);
    tick(); idle();

    // reset during an outstanding load that is answered in the reset cycle
    offer(T_LD, 5'd4, 32'h0, 1'b1); mid(); tick();
    idle(); mid(); tick();
    rst = 1'b1; lsu_vld = 1'b1; lsu_dat = 32'hCAFEF00D; mid();
    chk("rstld_we", we_a, 0); chk("rstld_done", done_a, 0); chk("rstld_we_b", we_b, 0);
    tick(); rst = 1'b0; idle(); mid();
    chk("rstld_ready", ready_a, 1); chk("rstld_cnt", cnt_a, 0); chk("rstld_out", out_a, 0);
    tick();

    // 17 completions wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      offer(T_OT, 5'(i + 1), $urandom, 1'b1); mid(); tick();
    end
    idle(); mid(); tick(); mid();
    chk("wrap_cnt_a", cnt_a, 17); chk("wrap_cnt_b", cnt_b, 1); tick();

    // randomized traffic; a stalled offer is held unchanged
    for (int c = 0; c < 3000; c++) begin
      if (!(en && !took)) begin
        if ($urandom_range(0, 9) < 7) begin
          offer(2'($urandom_range(0, 2)),
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                $urandom, 1'($urandom));
        end else begin
          en = 1'b0;
        end
      end
      lsu_vld = ($urandom_range(0, 9) < 3);
      lsu_err = ($urandom_range(0, 9) < 2);
      lsu_dat = $urandom;
      rst     = ($urandom_range(0, 99) == 0);
      mid(); tick();
    end
    rst = 1'b0; idle(); mid(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
